pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4, range 8..64.
REQ-002 Parameter STAGES, default 2, pipeline depth; SHALL divide WIDTH/4 evenly, range 1..WIDTH/4.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  unsigned/two's-complement operands.
REQ-008 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  raw carry out of MSB.
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  sum equals 0.

Function
REQ-016 Add: sum = a + b + cin mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-017 Sub: sum = a + ~b + (1 - cin), i.e. a - b - cin; cout = 0 signals borrow.
REQ-018 ovf = (opA[MSB] == opB'[MSB]) and (sum[MSB] != opA[MSB]), where opB' = b or ~b per mode.
REQ-019 Each stage covers WIDTH/STAGES bits as 4-bit lookahead groups, with group generate/propagate combined by lookahead inside the stage; stage carry SHALL be registered into the next stage.
REQ-020 Operand bits for stage k SHALL be skewed by k register levels; completed low result bits SHALL be delayed so all bits of one transaction emerge aligned.
REQ-021 Latency: a transaction accepted in cycle n SHALL appear with out_valid=1 in cycle n+STAGES if not stalled.
REQ-022 Global advance enable adv = ~out_valid | out_ready; in_ready = adv.
REQ-023 Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
REQ-024 When adv = 0, every pipeline register including sum/cout/ovf/zero/out_valid SHALL hold.
REQ-025 Per-stage valid bits SHALL track occupancy; bubbles propagate as invalid, never produce out_valid.
REQ-026 Throughput: one transaction per cycle with out_ready held high.
REQ-027 Simultaneous output pop and input push SHALL both complete in the same cycle.
REQ-028 Outputs other than out_valid are don't-care when out_valid = 0 but SHALL be deterministic (registered).
REQ-029 STAGES = 1: single register level, latency 1, identical handshake.

Reset
REQ-030 While rst = 1 at a clock edge: all stage valid bits, out_valid, sum, cout, ovf SHALL clear to 0; zero SHALL clear to 0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions; none SHALL emerge afterwards.
REQ-033 Inputs presented during reset SHALL not be accepted.

Structure
REQ-034 Shared package cla_pkg SHALL hold GROUP_BITS = 4 and a typedef for a group generate/propagate pair.
REQ-035 One sub-module, cla_stage, SHALL implement one stage's combinational lookahead add (parametrised width, carry-in, sum, carry-out, MSB carry for ovf); pipelined_cla_adder instantiates STAGES copies plus skew/valid registers.
REQ-036 No latches; no clock gating; no combinational path from out_ready to sum.

Verification
REQ-037 WIDTH=32, STAGES=2: a=0xFFFFFFFF, b=0, cin=1, add -> after 2 cycles sum=0, cout=1, zero=1, ovf=0.
REQ-038 a=0x7FFFFFFF, b=1, cin=0, add -> sum=0x80000000, ovf=1, cout=0; sub a=0, b=1, cin=0 -> sum=0xFFFFFFFF, cout=0, ovf=0.
REQ-039 Back-to-back 100 random transactions, out_ready=1 -> results in order, one per cycle, all match reference model.
REQ-040 Pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs stable; release -> no loss/duplication.
REQ-041 rst asserted with 2 transactions in flight -> out_valid=0 next cycle, no stale result emerges later.
REQ-042 Sweep STAGES in {1,2,4,8} at WIDTH=32 with random stalls -> latency equals STAGES, all results correct.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_BITS : bits per lookahead group
//   gp_t       : generate/propagate pair for a bit span
//   gp_combine : merge a higher span onto an adjacent lower span
package cla_pkg;

  localparam int unsigned GROUP_BITS = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Span (hi:lo) generates if hi generates, or hi propagates a carry generated in lo.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/cla_stage.sv
// One pipeline stage's combinational carry-lookahead adder.
//   a, b   : stage operand slices (b already conditioned for subtract)
//   cin    : carry into the slice LSB
//   sum    : slice sum
//   cout   : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (signed overflow = cout ^ c_msb)
module cla_stage
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int unsigned NG = WIDTH / GROUP_BITS;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NG:0]      gc;
  gp_t              bit_pre [WIDTH];
  gp_t              grp     [NG];

  assign g = a & b;
  assign p = a ^ b;

  // Bit prefixes inside each group, group G/P, then group carries by prefix over groups.
  always_comb begin
    gp_t bit_gp;
    gp_t acc;
    c       = '0;
    gc      = '0;
    bit_gp  = '0;
    acc     = '0;
    bit_pre = '{default: '0};
    grp     = '{default: '0};

    for (int gi = 0; gi < int'(NG); gi++) begin
      for (int j = 0; j < int'(GROUP_BITS); j++) begin
        bit_gp.g = g[gi*GROUP_BITS + j];
        bit_gp.p = p[gi*GROUP_BITS + j];
        if (j == 0) begin
          bit_pre[gi*GROUP_BITS] = bit_gp;
        end else begin
          bit_pre[gi*GROUP_BITS + j] = gp_combine(bit_gp, bit_pre[gi*GROUP_BITS + j - 1]);
        end
      end
      grp[gi] = bit_pre[gi*GROUP_BITS + GROUP_BITS - 1];
    end

    gc[0] = cin;
    for (int gi = 0; gi < int'(NG); gi++) begin
      acc       = (gi == 0) ? grp[0] : gp_combine(grp[gi], acc);
      gc[gi+1]  = acc.g | (acc.p & cin);
    end

    // Bit carries come from the in-group prefix applied to the group carry-in.
    for (int gi = 0; gi < int'(NG); gi++) begin
      c[gi*GROUP_BITS] = gc[gi];
      for (int j = 0; j < int'(GROUP_BITS) - 1; j++) begin
        c[gi*GROUP_BITS + j + 1] = bit_pre[gi*GROUP_BITS + j].g
                                 | (bit_pre[gi*GROUP_BITS + j].p & gc[gi]);
      end
    end
    c[WIDTH] = gc[NG];
  end

  assign sum   = p ^ c[WIDTH-1:0];
  assign cout  = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract built from STAGES lookahead slices with valid/ready flow.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = advance enable)
//   a, b, cin, sub       : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid / out_ready: result handshake
//   sum, cout, ovf, zero : registered result, raw MSB carry, signed overflow, sum==0
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] last_res;
  logic             last_co;
  logic             last_cm;
  logic             last_v;

  // Whole pipeline moves together; it only freezes behind an unaccepted result.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_st
    localparam int unsigned REM  = WIDTH - k*SW;   // operand bits not yet summed
    localparam int unsigned DONE = (k+1)*SW;       // result bits complete after this stage

    logic [REM-1:0]  ra;
    logic [REM-1:0]  rb;
    logic            rc;
    logic            rv;
    logic [DONE-1:0] res_d;
    logic [SW-1:0]   s;
    logic            co;
    logic            cm;

    // Subtract is a + ~b with inverted carry-in, so cin acts as borrow-in.
    if (k == 0) begin : g_in
      assign ra = a;
      assign rb = b ^ {WIDTH{sub}};
      assign rc = cin ^ sub;
      assign rv = in_valid & adv;
    end else begin : g_link
      assign ra = g_st[k-1].g_reg.a_q;
      assign rb = g_st[k-1].g_reg.b_q;
      assign rc = g_st[k-1].g_reg.c_q;
      assign rv = g_st[k-1].g_reg.v_q;
    end

    cla_stage #(.WIDTH(SW)) u_stage (
      .a    (ra[SW-1:0]),
      .b    (rb[SW-1:0]),
      .cin  (rc),
      .sum  (s),
      .cout (co),
      .c_msb(cm)
    );

    if (k == 0) begin : g_res0
      assign res_d = s;
    end else begin : g_resn
      assign res_d = {s, g_st[k-1].g_reg.r_q};
    end

    if (k < int'(STAGES) - 1) begin : g_reg
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      logic [DONE-1:0]   r_q;
      logic              c_q;
      logic              v_q;

      // Skew register: remaining high operand bits, finished low result bits, slice carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= ra[REM-1:SW];
          b_q <= rb[REM-1:SW];
          r_q <= res_d;
          c_q <= co;
          v_q <= rv;
        end
      end
    end else begin : g_last
      assign last_res = res_d;
      assign last_co  = co;
      assign last_cm  = cm;
      assign last_v   = rv;
    end
  end

  // Output register: final pipeline level.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= last_v;
      sum       <= last_res;
      cout      <= last_co;
      ovf       <= last_co ^ last_cm;
      zero      <= (last_res == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: four instances (STAGES 1,2,4,8 at WIDTH 32) share
// operand stimulus, each with its own out_ready and a queue-based reference model.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  logic [3:0]  in_ready_w;
  logic [3:0]  out_valid_w;
  logic [3:0]  out_ready_w;
  logic [3:0]  cout_w;
  logic [3:0]  ovf_w;
  logic [3:0]  zero_w;
  logic [31:0] sum_w [4];

  bit   chk_en;
  bit   stall_en;
  bit   final_chk;
  logic ready_force;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic on wide integers, overflow from signed range of the true result.
  function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi,
                                 input logic ci, input logic si);
    exp_t        e;
    longint unsigned ua, ub, ur;
    longint      sa, sb, sr;
    ua = 64'(ai);
    ub = 64'(bi);
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (!si) begin
      ur     = ua + ub + 64'(ci);
      sr     = sa + sb + longint'(ci);
      e.cout = (ur >= 64'h1_0000_0000);
    end else begin
      ur     = ua - ub - 64'(ci);
      sr     = sa - sb - longint'(ci);
      e.cout = (ua >= ub + 64'(ci));
    end
    e.sum  = 32'(ur);
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.zero = (e.sum == 32'd0);
    e.pos  = 1;
    return e;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int unsigned ST = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 8;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(ST)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_w[i]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid_w[i]),
      .out_ready(out_ready_w[i]),
      .sum      (sum_w[i]),
      .cout     (cout_w[i]),
      .ovf      (ovf_w[i]),
      .zero     (zero_w[i])
    );

    exp_t q[$];
    bit   final_done = 1'b0;

    // Each accepted item needs ST advancing edges to reach the output.
    always @(negedge clk) begin
      if (chk_en) begin
        logic ev;
        logic er;
        ev = (q.size() > 0) && (q[0].pos == int'(ST));
        er = !ev || out_ready_w[i];
        check($sformatf("S%0d out_valid", ST), 64'(out_valid_w[i]), 64'(ev));
        check($sformatf("S%0d in_ready", ST), 64'(in_ready_w[i]), 64'(er));
        if (ev && out_valid_w[i]) begin
          check($sformatf("S%0d sum", ST),  64'(sum_w[i]),  64'(q[0].sum));
          check($sformatf("S%0d cout", ST), 64'(cout_w[i]), 64'(q[0].cout));
          check($sformatf("S%0d ovf", ST),  64'(ovf_w[i]),  64'(q[0].ovf));
          check($sformatf("S%0d zero", ST), 64'(zero_w[i]), 64'(q[0].zero));
        end
        if (rst) begin
          q.delete();
        end else if (er) begin
          if (ev) void'(q.pop_front());
          foreach (q[j]) q[j].pos++;
          if (in_valid) q.push_back(model(a, b, cin, sub));
        end
        if (final_chk && !final_done) begin
          check($sformatf("S%0d drained", ST), 64'(q.size()), 64'd0);
          final_done = 1'b1;
        end
      end
    end
  end

  // Consumer: forced level or random back-pressure, changed 2 time units after the edge.
  initial begin
    out_ready_w = '1;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++)
        out_ready_w[i] = stall_en ? logic'($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ai, input logic [31:0] bi,
                       input logic ci, input logic si);
    in_valid = 1'b1;
    a   = ai;
    b   = bi;
    cin = ci;
    sub = si;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] pick [5];
    pick[0] = 32'h0000_0000;
    pick[1] = 32'hFFFF_FFFF;
    pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF;
    pick[4] = $urandom;
    return ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : pick[4];
  endfunction

  task automatic drive_rand();
    drive(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    exp_t m;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    ready_force = 1'b1; stall_en = 1'b0; chk_en = 1'b0; final_chk = 1'b0;

    // Pin the reference model with hand-computed results.
    m = model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check("model add wrap", {m.sum, 29'd0, m.cout, m.ovf, m.zero}, {32'h0, 29'd0, 3'b101});
    m = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("model add ovf", {m.sum, 29'd0, m.cout, m.ovf, m.zero}, {32'h8000_0000, 29'd0, 3'b010});
    m = model(32'h0, 32'h1, 1'b0, 1'b1);
    check("model sub borrow", {m.sum, 29'd0, m.cout, m.ovf, m.zero}, {32'hFFFF_FFFF, 29'd0, 3'b000});
    m = model(32'h5, 32'h3, 1'b1, 1'b1);
    check("model sub borrow-in", {m.sum, 29'd0, m.cout, m.ovf, m.zero}, {32'h1, 29'd0, 3'b100});

    step(); step();
    chk_en = 1'b1;
    check("reset out_valid", 64'(out_valid_w[1]), 64'd0);
    check("reset sum",       64'(sum_w[1]),       64'd0);
    check("reset cout",      64'(cout_w[1]),      64'd0);
    check("reset ovf",       64'(ovf_w[1]),       64'd0);
    check("reset zero",      64'(zero_w[1]),      64'd0);
    rst = 1'b0;
    check("in_ready after reset", 64'(in_ready_w[1]), 64'd1);

    // Carry ripples through every bit: 0xFFFFFFFF + 0 + 1.
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("wrap out_valid", 64'(out_valid_w[1]), 64'd1);
    check("wrap sum",       64'(sum_w[1]),       64'd0);
    check("wrap cout",      64'(cout_w[1]),      64'd1);
    check("wrap zero",      64'(zero_w[1]),      64'd1);
    check("wrap ovf",       64'(ovf_w[1]),       64'd0);

    // Signed overflow on add, then borrow on subtract, back to back.
    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    drive(32'h0, 32'h1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("ovf add sum",  64'(sum_w[1]),  64'h8000_0000);
    check("ovf add ovf",  64'(ovf_w[1]),  64'd1);
    check("ovf add cout", 64'(cout_w[1]), 64'd0);
    step();
    check("sub sum",  64'(sum_w[1]),  64'hFFFF_FFFF);
    check("sub cout", 64'(cout_w[1]), 64'd0);
    check("sub ovf",  64'(ovf_w[1]),  64'd0);

    // Back-to-back random stream with the consumer always ready.
    for (int n = 0; n < 100; n++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();

    // Fill, then hold the consumer off for five cycles.
    ready_force = 1'b0;
    repeat (3) begin
      drive_rand();
      step();
    end
    for (int n = 0; n < 5; n++) begin
      drive_rand();
      step();
      check("stall in_ready",  64'(in_ready_w[1]),  64'd0);
      check("stall out_valid", 64'(out_valid_w[1]), 64'd1);
    end
    ready_force = 1'b1;
    in_valid = 1'b0;
    repeat (12) step();

    // Reset with two in flight while a third operand set is offered.
    drive_rand();
    step();
    drive_rand();
    step();
    rst = 1'b1;
    drive_rand();
    step();
    check("flush out_valid", 64'(out_valid_w[1]), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (12) step();

    // Random traffic with random back-pressure on every depth.
    stall_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      drive_rand();
      in_valid = 1'($urandom_range(0, 1));
      step();
    end
    stall_en = 1'b0;
    in_valid = 1'b0;
    repeat (20) step();
    final_chk = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
